// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_pkg
// Description : Shared types, default sizes and helper functions for the
//               Gray-stream decoder: tracking-FSM state encoding, default
//               code/counter widths, a generic Gray-to-binary conversion and
//               a population count used for Hamming distance.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  localparam int unsigned C_WIDTH = 4;
  localparam int unsigned C_ERRW  = 8;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  // Width-generic Gray-to-binary: bits at or above w are forced to zero.
  // Callers pass a zero-extended code and the live width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i == w - 1) begin
        b[i] = g[i];
      end else if (i < w - 1) begin
        b[i] = b[i+1] ^ g[i];
      end
    end
    return b;
  endfunction

  // Number of set bits in a zero-extended vector of up to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray2bin_comb.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_comb
// Description : Combinational WIDTH-bit Gray-to-binary converter, the inverse
//               of the upstream binary-to-Gray encoder.
// Ports       : gray  in  WIDTH  Gray-coded value
//               bin   out WIDTH  binary equivalent
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin[WIDTH-1] = gray[WIDTH-1];

  // Each binary bit is the XOR of all Gray bits at or above it, built as a
  // ripple from the MSB down.
  generate
    for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_bit
      assign bin[i] = bin[i+1] ^ gray[i];
    end
  endgenerate

endmodule : gray2bin_comb
`default_nettype wire

// File: rtl/gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray_stream_decoder
// Description : Two-stage registered decoder for a stream of Gray-coded
//               position samples. Converts each accepted sample to binary,
//               checks it is a single-bit step from the held reference,
//               reports direction / wrap-around / illegal jumps and keeps a
//               saturating error count.
// Ports       : clk        in  1      clock, rising edge
//               rst_n      in  1      asynchronous active-low reset
//               gray_in    in  WIDTH  Gray sample
//               gray_valid in  1      sample strobe
//               bin_out    out WIDTH  binary of last processed sample
//               bin_valid  out 1      pulse per processed sample
//               step       out 1      pulse: legal single-bit step
//               dir        out 1      direction of last legal step (1 = up)
//               wrap       out 1      pulse: legal step crossed max <-> 0
//               step_err   out 1      pulse: Hamming distance > 1
//               err_count  out ERRW   saturating count of step_err events
//               locked     out 1      a valid reference is held
// Revision    : 1.0 - initial release
// ============================================================================
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH,
  parameter int unsigned ERRW  = C_ERRW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step,
  output logic             dir,
  output logic             wrap,
  output logic             step_err,
  output logic [ERRW-1:0]  err_count,
  output logic             locked
);

  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  // Stage 1
  logic [WIDTH-1:0] r_g1;
  logic             r_v1;

  // Stage 2 state and registered outputs
  state_t           r_state;
  logic [WIDTH-1:0] r_ref_g;
  logic [WIDTH-1:0] r_ref_b;
  logic [WIDTH-1:0] r_bin_out;
  logic             r_bin_valid;
  logic             r_step;
  logic             r_dir;
  logic             r_wrap;
  logic             r_step_err;
  logic [ERRW-1:0]  r_err_count;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_diff;
  logic [5:0]       w_dist;
  logic             w_up;
  logic             w_wrap;

  gray2bin_comb #(
    .WIDTH(WIDTH)
  ) u_gray2bin (
    .gray(r_g1),
    .bin (w_bin)
  );

  assign w_diff = r_g1 ^ r_ref_g;
  assign w_dist = popcount(32'(w_diff));
  assign w_up   = (w_bin == r_ref_b + c_one);
  assign w_wrap = ((r_ref_b == c_max) && (w_bin == '0)) ||
                  ((r_ref_b == '0) && (w_bin == c_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g1        <= '0;
      r_v1        <= 1'b0;
      r_state     <= ST_EMPTY;
      r_ref_g     <= '0;
      r_ref_b     <= '0;
      r_bin_out   <= '0;
      r_bin_valid <= 1'b0;
      r_step      <= 1'b0;
      r_dir       <= 1'b1;
      r_wrap      <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_g1        <= gray_in;
      r_v1        <= gray_valid;
      r_bin_valid <= 1'b0;
      r_step      <= 1'b0;
      r_wrap      <= 1'b0;
      r_step_err  <= 1'b0;

      if (r_v1) begin
        r_bin_valid <= 1'b1;
        r_bin_out   <= w_bin;
        case (r_state)
          // A fault discards the old reference, so the next sample is a
          // fresh start exactly like the first one after reset.
          ST_EMPTY, ST_FAULT: begin
            r_ref_g <= r_g1;
            r_ref_b <= w_bin;
            r_state <= ST_LOCKED;
          end
          ST_LOCKED: begin
            if (w_dist == 6'd1) begin
              r_step  <= 1'b1;
              r_dir   <= w_up;
              r_wrap  <= w_wrap;
              r_ref_g <= r_g1;
              r_ref_b <= w_bin;
            end else if (w_dist != 6'd0) begin
              r_step_err <= 1'b1;
              if (r_err_count != {ERRW{1'b1}}) begin
                r_err_count <= r_err_count + ERRW'(1);
              end
              r_state <= ST_FAULT;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign bin_out   = r_bin_out;
  assign bin_valid = r_bin_valid;
  assign step      = r_step;
  assign dir       = r_dir;
  assign wrap      = r_wrap;
  assign step_err  = r_step_err;
  assign err_count = r_err_count;
  assign locked    = (r_state == ST_LOCKED);

endmodule : gray_stream_decoder
`default_nettype wire
